ebi_link_serdes: RTL
====================

Name: ebi_link_serdes

Overview:
- Pin-level transceiver between the inner EBI transaction FSM and the EBI_WIDTH-bit bidirectional GPIO bus.
- Serializes a flat send buffer into EBI_WIDTH-bit beats, lowest beat first. Frame layout: start beat (all zeros), then opcode beat, then payload.
- Detects incoming start beats, decodes the opcode beat, and deserializes the payload into a flat response buffer for the upstream FSM.

Parameters:
- EBI_WIDTH, 16: GPIO bus width. One beat is EBI_WIDTH bits.
- PADDR_WIDTH, 32: address width. A = PADDR_WIDTH/EBI_WIDTH address beats.
- CACHELINE_LENGTH, 512: line size in bits. D = CACHELINE_LENGTH/EBI_WIDTH data beats.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ebi_i  in  EBI_WIDTH  pad input. Idle lines read all-ones (pull-ups).
- ebi_o  out  EBI_WIDTH  pad output
- ebi_oen  out  EBI_WIDTH  pad output enable, 0 = drive; all bits equal
- send_data  in  3*EBI_WIDTH+CACHELINE_LENGTH+PADDR_WIDTH  frame to send; beat k = bits [k*EBI_WIDTH +: EBI_WIDTH]
- opcode  in  4  opcode of the frame about to be sent; sampled on the reload cycle
- is_counter_reload  in  1  first cycle of a send or receive state
- is_counter_ena  in  1  beat counter advances
- is_send_mode  in  1  FSM is in a send state
- is_rd_rcv  in  1  FSM is in a receive state
- resp_data  out  CACHELINE_LENGTH+2*EBI_WIDTH  received payload, beat 0 at bit 0
- trx_rcv_start  out  1  start beat detected (combinational)
- trx_send_done  out  1  last beat being driven this cycle
- trx_rcv_done  out  1  last payload beat captured at this edge
- rcv_opcode_o  out  4  opcode of the last received frame (registered)
- rcv_err_o  out  1  illegal received opcode; present only with the macro, else tied 0

Behaviour:
- Reset: ebi_oen all-1, ebi_o 0, resp_data 0, rcv_opcode_o 0, rcv_err_o 0, beat counter 0, length registers 0, holdoff 0.
- Send frame total length N is latched from opcode on the cycle where is_counter_reload & is_send_mode:
  - 0 (DR): N = A+4
  - 1 (DW1): N = A+3+D
  - 2 (DW2): N = A+3
  - 3 (SNP_RESP1): N = D+2
  - 4 (SNP_RESP2): N = 2
  - any other opcode: N = 2
- Send cycle behaviour:
  - Reload cycle drives beat 0; counter is then set to 1.
  - Each following send-mode cycle drives beat cnt and increments cnt.
  - ebi_o/ebi_oen are combinational from the counter and send_data, so a beat appears in the same cycle.
  - ebi_oen is 0 exactly N cycles, otherwise all-1.
  - trx_send_done = 1 in the cycle driving beat N-1.
  - If is_send_mode drops early, the frame aborts and ebi_oen returns to all-1 in the same cycle.
- Listening is active when !is_send_mode & !is_rd_rcv.
- trx_rcv_start = listen & (ebi_i == 0) & !holdoff.
  - holdoff is a register set for the one cycle after a start detection; it masks the opcode beat.
- Receive, reload cycle (is_counter_reload & is_rd_rcv): capture ebi_i[3:0] into rcv_opcode_o and set payload length P:
  - 7 (RD_RESP): P = D+2
  - 6 (SNP_REQ): P = A+1
  - 0xF (ACK): P = 0
  - other opcodes: P = 0
- If P == 0, trx_rcv_done = 1 in the reload cycle.
- Receive, payload: cycle k (1..P) writes ebi_i into resp_data[(k-1)*EBI_WIDTH +: EBI_WIDTH] at the clock edge. trx_rcv_done = 1 in cycle k = P.
- Bits of resp_data not written by the current frame hold their previous value.
- RD_RESP payload layout: data at bits [0, CACHELINE_LENGTH), mesi at bit CACHELINE_LENGTH, rid at bit CACHELINE_LENGTH+EBI_WIDTH.
- SNP_REQ payload layout: address in beats 0..A-1, snoop in beat A.
- is_counter_reload has priority over counter increment. A reload mid-frame restarts the counter at the new frame.
- Send and receive are never requested together. If both are requested, send wins and receive inputs are ignored.
- Reset mid-frame: returns to reset values on the next edge, and ebi_oen releases immediately after that edge.

Optional Feature:
- Macro: EBI_RX_OPCODE_CHECK_EN.
- Defined: a received opcode outside {6, 7, 0xF}:
  - pulses rcv_err_o for 1 cycle together with trx_rcv_done;
  - sets P = 0;
  - leaves resp_data untouched.
- Undefined: rcv_err_o is tied 0. Unknown opcodes are silently treated as P = 0.

Test Plan:
- DR send: opcode=0, send_data beats {0000,0000,addr_lo=1234,addr_hi=8000,snoop=0003,id=0001} → ebi_oen=0 for exactly 6 cycles, the beats appear in that order, trx_send_done in the 6th cycle.
- DW1 send: opcode=1 with 32 data beats 0x0000..0x001F → 37 beats driven, data beat 5 = 0x0000, last beat 0x001F with trx_send_done; ebi_oen all-1 on the next cycle.
- RD_RESP receive: ebi_i = 0000 (start), 0007, 32 beats 0xA000+i, mesi 0003, rid 0002 → trx_rcv_start on the start beat, trx_rcv_done on the 36th beat, resp_data[15:0]=A000, resp_data[512+:2]=3, resp_data[528+:2]=2.
- ACK: listening sees 0000 then 000F → trx_rcv_start once (no second pulse on the opcode beat); next state reload gives trx_rcv_done the same cycle, rcv_opcode_o=F.
- SNP_REQ: start, 0006, 5678, 8000, 0002 → trx_rcv_done on the 3rd payload beat, resp_data[31:0]=80005678, resp_data[35:32]=2.
- Illegal opcode 0x9 received with EBI_RX_OPCODE_CHECK_EN → rcv_err_o=1 and trx_rcv_done in the reload cycle, resp_data unchanged. Without the macro → rcv_err_o stays 0. Assert rst mid-DW1 send → ebi_oen all-1 after the edge.

Source files
------------

// File: rtl/ebi_link_serdes_if.sv
// Upstream-FSM side of the EBI link transceiver: frame to send, control strobes, receive results.
interface ebi_link_serdes_if #(
  parameter int unsigned EBI_WIDTH        = 16,
  parameter int unsigned PADDR_WIDTH      = 32,
  parameter int unsigned CACHELINE_LENGTH = 512
);
  logic [3*EBI_WIDTH+CACHELINE_LENGTH+PADDR_WIDTH-1:0] send_data;
  logic [3:0]                                          opcode;
  logic                                                is_counter_reload;
  logic                                                is_counter_ena;
  logic                                                is_send_mode;
  logic                                                is_rd_rcv;
  logic [CACHELINE_LENGTH+2*EBI_WIDTH-1:0]             resp_data;
  logic                                                trx_rcv_start;
  logic                                                trx_send_done;
  logic                                                trx_rcv_done;
  logic [3:0]                                          rcv_opcode_o;
  logic                                                rcv_err_o;

  modport master (
    output send_data, opcode, is_counter_reload, is_counter_ena, is_send_mode, is_rd_rcv,
    input  resp_data, trx_rcv_start, trx_send_done, trx_rcv_done, rcv_opcode_o, rcv_err_o
  );

  modport slave (
    input  send_data, opcode, is_counter_reload, is_counter_ena, is_send_mode, is_rd_rcv,
    output resp_data, trx_rcv_start, trx_send_done, trx_rcv_done, rcv_opcode_o, rcv_err_o
  );
endinterface

// File: rtl/ebi_link_serdes.sv
// Beat-level serializer/deserializer between the EBI transaction FSM and the GPIO pad bus.
// Define EBI_RX_OPCODE_CHECK_EN to flag illegal received opcodes on rcv_err_o.
module ebi_link_serdes #(
  parameter int unsigned EBI_WIDTH        = 16,
  parameter int unsigned PADDR_WIDTH      = 32,
  parameter int unsigned CACHELINE_LENGTH = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EBI_WIDTH-1:0] ebi_i,
  output logic [EBI_WIDTH-1:0] ebi_o,
  output logic [EBI_WIDTH-1:0] ebi_oen,
  ebi_link_serdes_if.slave     fsm
);
  localparam int unsigned A         = PADDR_WIDTH / EBI_WIDTH;
  localparam int unsigned D         = CACHELINE_LENGTH / EBI_WIDTH;
  localparam int unsigned SendBeats = 3 + A + D;
  localparam int unsigned RespBeats = 2 + D;
  localparam int unsigned RespW     = RespBeats * EBI_WIDTH;
  localparam int unsigned CntW      = $clog2(SendBeats + 1);
  localparam logic [CntW-1:0] CntMax = '1;

  localparam logic [3:0] OpDr       = 4'h0;
  localparam logic [3:0] OpDw1      = 4'h1;
  localparam logic [3:0] OpDw2      = 4'h2;
  localparam logic [3:0] OpSnpResp1 = 4'h3;
  localparam logic [3:0] OpSnpResp2 = 4'h4;
  localparam logic [3:0] OpSnpReq   = 4'h6;
  localparam logic [3:0] OpRdResp   = 4'h7;
  localparam logic [3:0] OpAck      = 4'hF;

  function automatic logic [CntW-1:0] send_len(input logic [3:0] op);
    case (op)
      OpDr:       return CntW'(A + 4);
      OpDw1:      return CntW'(A + 3 + D);
      OpDw2:      return CntW'(A + 3);
      OpSnpResp1: return CntW'(D + 2);
      OpSnpResp2: return CntW'(2);
      default:    return CntW'(2);
    endcase
  endfunction

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      slen_q, slen_d;
  logic [CntW-1:0]      plen_q, plen_d;
  logic                 holdoff_q, holdoff_d;
  logic [3:0]           rcv_op_q, rcv_op_d;
  logic [RespW-1:0]     resp_q, resp_d;

  logic                 send_reload, rcv_reload, listen;
  logic                 send_drive, rcv_beat, rcv_start;
  logic [CntW-1:0]      sidx, slen_now, rcv_plen, rbeat;
  logic [3:0]           rcv_op_in;
  logic [EBI_WIDTH-1:0] send_beat;

  // Send wins if the FSM ever requests both directions at once.
  assign send_reload = fsm.is_counter_reload & fsm.is_send_mode;
  assign rcv_reload  = fsm.is_counter_reload & fsm.is_rd_rcv & ~fsm.is_send_mode;
  assign listen      = ~fsm.is_send_mode & ~fsm.is_rd_rcv;

  // On the reload cycle the length is not latched yet, so decode it straight from opcode.
  assign sidx       = send_reload ? '0 : cnt_q;
  assign slen_now   = send_reload ? send_len(fsm.opcode) : slen_q;
  assign send_drive = fsm.is_send_mode & (sidx < slen_now);

  always_comb begin
    send_beat = '0;
    for (int k = 0; k < SendBeats; k++) begin
      if (sidx == CntW'(k)) send_beat = fsm.send_data[k*EBI_WIDTH +: EBI_WIDTH];
    end
  end

  assign ebi_o             = send_drive ? send_beat : '0;
  assign ebi_oen           = send_drive ? '0 : '1;
  assign fsm.trx_send_done = send_drive & (sidx == slen_now - CntW'(1));

  assign rcv_op_in = ebi_i[3:0];

  always_comb begin
    case (rcv_op_in)
      OpRdResp: rcv_plen = CntW'(D + 2);
      OpSnpReq: rcv_plen = CntW'(A + 1);
      default:  rcv_plen = '0;
    endcase
  end

  assign rcv_start = listen & (ebi_i == '0) & ~holdoff_q;
  assign rcv_beat  = fsm.is_rd_rcv & ~fsm.is_send_mode & ~fsm.is_counter_reload &
                     (cnt_q != '0) & (cnt_q <= plen_q);
  assign rbeat     = cnt_q - CntW'(1);

  assign fsm.trx_rcv_start = rcv_start;
  assign fsm.trx_rcv_done  = (rcv_reload & (rcv_plen == '0)) | (rcv_beat & (cnt_q == plen_q));
  assign fsm.resp_data     = resp_q;
  assign fsm.rcv_opcode_o  = rcv_op_q;

`ifdef EBI_RX_OPCODE_CHECK_EN
  assign fsm.rcv_err_o = rcv_reload & ~(rcv_op_in inside {OpSnpReq, OpRdResp, OpAck});
`else
  assign fsm.rcv_err_o = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    slen_d    = slen_q;
    plen_d    = plen_q;
    rcv_op_d  = rcv_op_q;
    resp_d    = resp_q;
    holdoff_d = rcv_start;
    if (send_reload) begin
      cnt_d  = CntW'(1);
      slen_d = send_len(fsm.opcode);
    end else if (rcv_reload) begin
      cnt_d    = CntW'(1);
      plen_d   = rcv_plen;
      rcv_op_d = rcv_op_in;
    end else if (fsm.is_counter_ena && (fsm.is_send_mode || fsm.is_rd_rcv) &&
                 (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    for (int k = 0; k < RespBeats; k++) begin
      if (rcv_beat && (rbeat == CntW'(k))) resp_d[k*EBI_WIDTH +: EBI_WIDTH] = ebi_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      slen_q    <= '0;
      plen_q    <= '0;
      holdoff_q <= 1'b0;
      rcv_op_q  <= '0;
      resp_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      slen_q    <= slen_d;
      plen_q    <= plen_d;
      holdoff_q <= holdoff_d;
      rcv_op_q  <= rcv_op_d;
      resp_q    <= resp_d;
    end
  end
endmodule
